// File: rtl/pcie_ltssm_tx_sched.sv
// LTSSM transmit scheduler: shares one 4-symbol TX path between ordered sets,
// periodic SKP insertion and the data-link AXIS stream without splitting any of them.
module pcie_ltssm_tx_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = DATA_WIDTH/8,
  parameter int SKP_INTERVAL = 354,
  parameter int CNT_WIDTH    = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  os_req_i,
  input  logic [1:0]            os_type_i,
  input  logic [7:0]            link_num_i,
  input  logic [7:0]            lane_num_i,
  input  logic                  pad_link_i,
  input  logic                  pad_lane_i,
  input  logic [7:0]            n_fts_i,
  input  logic [7:0]            rate_id_i,
  input  logic [7:0]            train_ctrl_i,
  output logic                  os_ack_o,
  input  logic                  data_en_i,
  input  logic                  skp_en_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_i,
  input  logic [KEEP_WIDTH-1:0] s_axis_tuser_i,
  input  logic                  s_axis_tvalid_i,
  input  logic                  s_axis_tlast_i,
  output logic                  s_axis_tready_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep_o,
  output logic [KEEP_WIDTH-1:0] m_axis_tuser_o,
  output logic                  m_axis_tvalid_o,
  output logic                  m_axis_tlast_o,
  input  logic                  m_axis_tready_i,
  output logic                  skp_sent_o
);

  // state | meaning
  // IDLE  | arbitrating SKP > OS > data whenever the output register is loadable
  // DATA  | passing AXIS beats through until a tlast beat is loaded
  // OS    | emitting the captured TS1/TS2 (4 beats) or EIOS (1 beat)
  // SKP   | SKP beat presented, waiting for acceptance
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_OS   = 2'd2;
  localparam logic [1:0] ST_SKP  = 2'd3;

  localparam logic [1:0] OS_TS2  = 2'd1;
  localparam logic [1:0] OS_EIOS = 2'd2;

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_IDL = 8'h7C;
  localparam logic [7:0] SYM_PAD = 8'hF7;
  localparam logic [7:0] TS1_ID  = 8'h4A;
  localparam logic [7:0] TS2_ID  = 8'h45;

  localparam logic [CNT_WIDTH-1:0] SKP_LAST = CNT_WIDTH'(SKP_INTERVAL - 1);

  logic [1:0]           state_q, state_d;
  logic [1:0]           beat_q, beat_d;
  logic [1:0]           os_type_q;
  logic [7:0]           link_q, lane_q, n_fts_q, rate_q, ctrl_q;
  logic                 pad_link_q, pad_lane_q;
  logic                 capture;
  logic [CNT_WIDTH-1:0] skp_cnt_q;
  logic                 skp_pending_q;

  logic                  vld_d, last_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [KEEP_WIDTH-1:0] keep_d, user_d;

  logic        load, accept, os_last;
  logic [35:0] grant_beat, next_beat;

  // Returns {k_flags, symbols} for one ordered-set beat; reserved type behaves as TS1.
  function automatic logic [35:0] os_beat(
    input logic [1:0] typ,
    input logic [1:0] idx,
    input logic [7:0] link,
    input logic [7:0] lane,
    input logic       pad_link,
    input logic       pad_lane,
    input logic [7:0] nfts,
    input logic [7:0] rate,
    input logic [7:0] ctrl
  );
    logic [7:0]  id, s1, s2;
    logic [35:0] r;
    id = (typ == OS_TS2) ? TS2_ID : TS1_ID;
    s1 = pad_link ? SYM_PAD : link;
    s2 = pad_lane ? SYM_PAD : lane;
    r  = {4'b0000, id, id, id, id};
    if (typ == OS_EIOS) begin
      r = {4'hF, SYM_IDL, SYM_IDL, SYM_IDL, SYM_COM};
    end else begin
      case (idx)
        2'd0:    r = {1'b0, pad_lane, pad_link, 1'b1, nfts, s2, s1, SYM_COM};
        2'd1:    r = {4'b0000, id, id, ctrl, rate};
        default: r = {4'b0000, id, id, id, id};
      endcase
    end
    return r;
  endfunction

  assign load   = !m_axis_tvalid_o || m_axis_tready_i;
  assign accept = m_axis_tvalid_o && m_axis_tready_i;

  assign os_last = (os_type_q == OS_EIOS) || (beat_q == 2'd3);

  assign grant_beat = os_beat(os_type_i, 2'd0, link_num_i, lane_num_i, pad_link_i,
                              pad_lane_i, n_fts_i, rate_id_i, train_ctrl_i);
  assign next_beat  = os_beat(os_type_q, beat_q + 2'd1, link_q, lane_q, pad_link_q,
                              pad_lane_q, n_fts_q, rate_q, ctrl_q);

  assign s_axis_tready_o = (state_q == ST_DATA) && load;
  assign os_ack_o        = (state_q == ST_OS) && accept && os_last;
  assign skp_sent_o      = (state_q == ST_SKP) && accept;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    capture = 1'b0;
    vld_d   = m_axis_tvalid_o;
    data_d  = m_axis_tdata_o;
    keep_d  = m_axis_tkeep_o;
    user_d  = m_axis_tuser_o;
    last_d  = m_axis_tlast_o;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          vld_d = 1'b0;
          if (skp_pending_q) begin
            vld_d   = 1'b1;
            data_d  = {SYM_SKP, SYM_SKP, SYM_SKP, SYM_COM};
            keep_d  = '1;
            user_d  = '1;
            last_d  = 1'b1;
            state_d = ST_SKP;
          end else if (os_req_i) begin
            capture          = 1'b1;
            vld_d            = 1'b1;
            {user_d, data_d} = grant_beat;
            keep_d           = '1;
            last_d           = (os_type_i == OS_EIOS);
            beat_d           = 2'd0;
            state_d          = ST_OS;
          end else if (data_en_i && s_axis_tvalid_i) begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (load) begin
          vld_d  = s_axis_tvalid_i;
          data_d = s_axis_tdata_i;
          keep_d = s_axis_tkeep_i;
          user_d = s_axis_tuser_i;
          last_d = s_axis_tlast_i;
          if (s_axis_tvalid_i && s_axis_tlast_i) state_d = ST_IDLE;
        end
      end
      ST_OS: begin
        if (accept) begin
          if (os_last) begin
            vld_d   = 1'b0;
            last_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            {user_d, data_d} = next_beat;
            keep_d           = '1;
            last_d           = (beat_q == 2'd2);
            beat_d           = beat_q + 2'd1;
          end
        end
      end
      ST_SKP: begin
        if (accept) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      beat_q          <= 2'd0;
      m_axis_tvalid_o <= 1'b0;
      m_axis_tdata_o  <= '0;
      m_axis_tkeep_o  <= '0;
      m_axis_tuser_o  <= '0;
      m_axis_tlast_o  <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      m_axis_tvalid_o <= vld_d;
      m_axis_tdata_o  <= data_d;
      m_axis_tkeep_o  <= keep_d;
      m_axis_tuser_o  <= user_d;
      m_axis_tlast_o  <= last_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      os_type_q  <= 2'd0;
      link_q     <= 8'd0;
      lane_q     <= 8'd0;
      pad_link_q <= 1'b0;
      pad_lane_q <= 1'b0;
      n_fts_q    <= 8'd0;
      rate_q     <= 8'd0;
      ctrl_q     <= 8'd0;
    end else if (capture) begin
      os_type_q  <= os_type_i;
      link_q     <= link_num_i;
      lane_q     <= lane_num_i;
      pad_link_q <= pad_link_i;
      pad_lane_q <= pad_lane_i;
      n_fts_q    <= n_fts_i;
      rate_q     <= rate_id_i;
      ctrl_q     <= train_ctrl_i;
    end
  end

  // An expiry coinciding with the SKP acceptance re-arms pending rather than being lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skp_cnt_q     <= '0;
      skp_pending_q <= 1'b0;
    end else if (!skp_en_i) begin
      skp_cnt_q     <= '0;
      skp_pending_q <= 1'b0;
    end else if (skp_cnt_q == SKP_LAST) begin
      skp_cnt_q     <= '0;
      skp_pending_q <= 1'b1;
    end else begin
      skp_cnt_q <= skp_cnt_q + 1'b1;
      if (skp_sent_o) skp_pending_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcie_ltssm_tx_sched.sv
// Bench for pcie_ltssm_tx_sched: directed scenarios plus random traffic against a
// queue-based reference model, compared every cycle.
module tb_pcie_ltssm_tx_sched;
  localparam int SKP_IV = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        os_req_i;
  logic [1:0]  os_type_i;
  logic [7:0]  link_num_i, lane_num_i, n_fts_i, rate_id_i, train_ctrl_i;
  logic        pad_link_i, pad_lane_i;
  logic        os_ack_o;
  logic        data_en_i, skp_en_i;
  logic [31:0] s_axis_tdata_i;
  logic [3:0]  s_axis_tkeep_i, s_axis_tuser_i;
  logic        s_axis_tvalid_i, s_axis_tlast_i, s_axis_tready_o;
  logic [31:0] m_axis_tdata_o;
  logic [3:0]  m_axis_tkeep_o, m_axis_tuser_o;
  logic        m_axis_tvalid_o, m_axis_tlast_o, m_axis_tready_i;
  logic        skp_sent_o;

  always #5 clk_i = ~clk_i;

  pcie_ltssm_tx_sched #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .SKP_INTERVAL(SKP_IV), .CNT_WIDTH(12)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .os_req_i(os_req_i), .os_type_i(os_type_i),
    .link_num_i(link_num_i), .lane_num_i(lane_num_i),
    .pad_link_i(pad_link_i), .pad_lane_i(pad_lane_i),
    .n_fts_i(n_fts_i), .rate_id_i(rate_id_i), .train_ctrl_i(train_ctrl_i),
    .os_ack_o(os_ack_o), .data_en_i(data_en_i), .skp_en_i(skp_en_i),
    .s_axis_tdata_i(s_axis_tdata_i), .s_axis_tkeep_i(s_axis_tkeep_i),
    .s_axis_tuser_i(s_axis_tuser_i), .s_axis_tvalid_i(s_axis_tvalid_i),
    .s_axis_tlast_i(s_axis_tlast_i), .s_axis_tready_o(s_axis_tready_o),
    .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tkeep_o(m_axis_tkeep_o),
    .m_axis_tuser_o(m_axis_tuser_o), .m_axis_tvalid_o(m_axis_tvalid_o),
    .m_axis_tlast_o(m_axis_tlast_o), .m_axis_tready_i(m_axis_tready_i),
    .skp_sent_o(skp_sent_o)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [3:0]  u;
    logic        l;
  } beat_t;

  typedef struct {
    int          c;
    logic [31:0] d;
    logic [3:0]  u;
    logic        l;
  } log_t;

  localparam int K_IDLE = 0, K_PKT = 1, K_OS = 2, K_SKP = 3;

  int    n_pass = 0, n_total = 0, cyc = 0;
  beat_t os_q[$];
  beat_t src_q[$];
  log_t  log_q[$];
  int    sent_cyc[$];
  int    acks = 0, ack_cyc = 0;
  bit    last_ack = 0, src_gaps = 0;
  bit    mv;
  beat_t mo;
  int    kind, mcnt;
  bit    mpend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    mv = 0; mo = '0; kind = K_IDLE; mcnt = 0; mpend = 0;
    os_q.delete();
  endtask

  // Expands the requested ordered set into 16 (or 4) symbols and packs them into beats.
  task automatic build_os();
    logic [7:0] sym[16];
    bit         ksym[16];
    int         n;
    logic [7:0] id;
    beat_t      b;
    for (int i = 0; i < 16; i++) begin sym[i] = 8'h00; ksym[i] = 0; end
    if (os_type_i == 2'd2) begin
      n = 4;
      sym[0] = 8'hBC; ksym[0] = 1;
      for (int i = 1; i < 4; i++) begin sym[i] = 8'h7C; ksym[i] = 1; end
    end else begin
      n = 16;
      id = (os_type_i == 2'd1) ? 8'h45 : 8'h4A;
      sym[0] = 8'hBC; ksym[0] = 1;
      sym[1] = pad_link_i ? 8'hF7 : link_num_i; ksym[1] = pad_link_i;
      sym[2] = pad_lane_i ? 8'hF7 : lane_num_i; ksym[2] = pad_lane_i;
      sym[3] = n_fts_i;
      sym[4] = rate_id_i;
      sym[5] = train_ctrl_i;
      for (int i = 6; i < 16; i++) sym[i] = id;
    end
    for (int bi = 0; bi < n / 4; bi++) begin
      b.d = {sym[4*bi+3], sym[4*bi+2], sym[4*bi+1], sym[4*bi]};
      b.u = {ksym[4*bi+3], ksym[4*bi+2], ksym[4*bi+1], ksym[4*bi]};
      b.k = 4'hF;
      b.l = (bi == n / 4 - 1);
      os_q.push_back(b);
    end
  endtask

  task automatic model_step(input bit ld, input bit acc);
    bit pend_old, sent;
    pend_old = mpend;
    sent     = acc && (kind == K_SKP);
    case (kind)
      K_IDLE: if (ld) begin
        if (pend_old) begin
          mo.d = 32'h1C1C1CBC; mo.k = 4'hF; mo.u = 4'hF; mo.l = 1; mv = 1; kind = K_SKP;
        end else if (os_req_i) begin
          build_os();
          mo = os_q.pop_front(); mv = 1; kind = K_OS;
        end else begin
          mv = 0;
          if (data_en_i && s_axis_tvalid_i) kind = K_PKT;
        end
      end
      K_PKT: if (ld) begin
        mv = s_axis_tvalid_i;
        if (s_axis_tvalid_i) begin
          mo.d = s_axis_tdata_i; mo.k = s_axis_tkeep_i; mo.u = s_axis_tuser_i; mo.l = s_axis_tlast_i;
          if (s_axis_tlast_i) kind = K_IDLE;
        end
      end
      K_OS: if (acc) begin
        if (os_q.size() == 0) begin mv = 0; kind = K_IDLE; end
        else mo = os_q.pop_front();
      end
      default: if (acc) begin mv = 0; kind = K_IDLE; end
    endcase
    if (!skp_en_i) begin
      mcnt = 0; mpend = 0;
    end else begin
      mcnt = (mcnt + 1) % SKP_IV;
      if (mcnt == 0) mpend = 1;
      else if (sent) mpend = 0;
    end
  endtask

  task automatic drive_src(input bit taken);
    if (s_axis_tvalid_i && !taken) return;
    if (src_q.size() > 0 && (!src_gaps || $urandom_range(3) != 0)) begin
      s_axis_tvalid_i = 1;
      s_axis_tdata_i  = src_q[0].d;
      s_axis_tkeep_i  = src_q[0].k;
      s_axis_tuser_i  = src_q[0].u;
      s_axis_tlast_i  = src_q[0].l;
    end else begin
      s_axis_tvalid_i = 0;
    end
  endtask

  // One cycle: compare at negedge+1, log handshakes, advance model, move to next negedge.
  task automatic tick();
    bit ld, acc, e_tready, e_ack, e_sent, taken;
    log_t e;
    #1;
    ld       = !mv || m_axis_tready_i;
    acc      = mv && m_axis_tready_i;
    e_tready = rst_ni && (kind == K_PKT) && ld;
    e_ack    = rst_ni && acc && (kind == K_OS) && (os_q.size() == 0);
    e_sent   = rst_ni && acc && (kind == K_SKP);
    chk("tvalid", m_axis_tvalid_o, mv);
    if (mv) begin
      chk("tdata", m_axis_tdata_o, mo.d);
      chk("tkeep", m_axis_tkeep_o, mo.k);
      chk("tuser", m_axis_tuser_o, mo.u);
      chk("tlast", m_axis_tlast_o, mo.l);
    end
    chk("s_tready", s_axis_tready_o, e_tready);
    chk("os_ack", os_ack_o, e_ack);
    chk("skp_sent", skp_sent_o, e_sent);
    if (m_axis_tvalid_o && m_axis_tready_i) begin
      e.c = cyc; e.d = m_axis_tdata_o; e.u = m_axis_tuser_o; e.l = m_axis_tlast_o;
      log_q.push_back(e);
    end
    last_ack = os_ack_o;
    if (os_ack_o) begin acks++; ack_cyc = cyc; end
    if (skp_sent_o) sent_cyc.push_back(cyc);
    taken = s_axis_tvalid_i && s_axis_tready_o;
    if (!rst_ni) model_reset();
    else model_step(ld, acc);
    @(negedge clk_i);
    cyc++;
    if (taken && src_q.size() > 0) void'(src_q.pop_front());
    drive_src(taken);
  endtask

  task automatic run_until_ack(input int maxc, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (last_ack) begin ok = 1; break; end
    end
    chk(name, ok, 1);
    os_req_i = 0;
  endtask

  task automatic set_ts(input logic [1:0] t);
    os_type_i = t; link_num_i = 8'h05; lane_num_i = 8'h33; pad_link_i = 0; pad_lane_i = 1;
    n_fts_i = 8'h10; rate_id_i = 8'h02; train_ctrl_i = 8'h00;
  endtask

  task automatic clear_logs();
    log_q.delete(); sent_cyc.delete(); acks = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit tog;
    beat_t b;
    int c0, np;
    rst_ni = 0; os_req_i = 0; set_ts(2'd0); data_en_i = 0; skp_en_i = 0;
    s_axis_tdata_i = 0; s_axis_tkeep_i = 0; s_axis_tuser_i = 0; s_axis_tvalid_i = 0;
    s_axis_tlast_i = 0; m_axis_tready_i = 1;
    model_reset();
    @(negedge clk_i);
    tick(); tick();
    chk("rst_tvalid", m_axis_tvalid_o, 0);
    chk("rst_tdata", m_axis_tdata_o, 0);
    chk("rst_tuser", m_axis_tuser_o, 0);
    chk("rst_tlast", m_axis_tlast_o, 0);
    rst_ni = 1;
    tick();

    // TS1 with lane PAD
    clear_logs(); set_ts(2'd0); os_req_i = 1;
    run_until_ack(20, "ts1_ack_timeout");
    tick(); tick();
    chk("ts1_beats", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("ts1_b0_data", log_q[0].d, 32'h10F705BC);
      chk("ts1_b0_user", log_q[0].u, 4'b0101);
      chk("ts1_b1_data", log_q[1].d, 32'h4A4A0002);
      chk("ts1_b2_data", log_q[2].d, 32'h4A4A4A4A);
      chk("ts1_b3_data", log_q[3].d, 32'h4A4A4A4A);
      chk("ts1_b3_user", log_q[3].u, 4'b0000);
      chk("ts1_b2_last", log_q[2].l, 0);
      chk("ts1_b3_last", log_q[3].l, 1);
      chk("ts1_contig", log_q[3].c - log_q[0].c, 3);
    end
    chk("ts1_acks", acks, 1);

    // Periodic SKP from idle
    clear_logs(); skp_en_i = 1; c0 = cyc;
    for (int i = 0; i < 40; i++) tick();
    chk("skp_count", sent_cyc.size(), 4);
    if (sent_cyc.size() == 4) begin
      chk("skp_first", sent_cyc[0] - c0, 9);
      for (int i = 1; i < 4; i++) chk("skp_period", sent_cyc[i] - sent_cyc[i-1], SKP_IV);
    end
    if (log_q.size() > 0) begin
      chk("skp_data", log_q[0].d, 32'h1C1C1CBC);
      chk("skp_user", log_q[0].u, 4'hF);
      chk("skp_last", log_q[0].l, 1);
    end
    skp_en_i = 0;
    for (int i = 0; i < 4; i++) tick();

    // 10-beat packet with an SKP expiry mid-packet
    clear_logs(); skp_en_i = 1;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 10; i++) begin
      b.d = 32'hD000_0000 + i; b.k = 4'hF; b.u = 4'h0; b.l = (i == 9);
      src_q.push_back(b);
    end
    data_en_i = 1;
    drive_src(0);
    for (int i = 0; i < 16; i++) tick();
    chk("pkt_log_size", log_q.size() >= 11, 1);
    if (log_q.size() >= 11) begin
      for (int i = 0; i < 10; i++) begin
        chk("pkt_data", log_q[i].d, 32'hD000_0000 + i);
        if (i > 0) chk("pkt_contig", log_q[i].c - log_q[i-1].c, 1);
      end
      chk("pkt_last", log_q[9].l, 1);
      chk("pkt_then_skp", log_q[10].d, 32'h1C1C1CBC);
    end
    skp_en_i = 0; data_en_i = 0;
    for (int i = 0; i < 6; i++) tick();

    // EIOS request and SKP expiry in the same cycle
    clear_logs(); skp_en_i = 1;
    for (int i = 0; i < SKP_IV; i++) tick();
    os_type_i = 2'd2; os_req_i = 1;
    run_until_ack(20, "eios_ack_timeout");
    skp_en_i = 0;
    tick();
    chk("eios_log_size", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("eios_skp_first", log_q[0].d, 32'h1C1C1CBC);
      chk("eios_data", log_q[1].d, 32'h7C7C7CBC);
      chk("eios_user", log_q[1].u, 4'hF);
      chk("eios_last", log_q[1].l, 1);
      chk("eios_ack_cycle", ack_cyc, log_q[1].c);
    end
    chk("eios_acks", acks, 1);
    for (int i = 0; i < 3; i++) tick();

    // TS2 with ready toggling 1010
    clear_logs(); set_ts(2'd1); os_req_i = 1; tog = 1;
    for (int i = 0; i < 30; i++) begin
      m_axis_tready_i = tog; tog = !tog;
      tick();
      if (last_ack) break;
    end
    os_req_i = 0; m_axis_tready_i = 1;
    tick(); tick();
    chk("ts2_beats", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("ts2_b1_data", log_q[1].d, 32'h45450002);
      chk("ts2_b2_data", log_q[2].d, 32'h45454545);
      chk("ts2_b3_last", log_q[3].l, 1);
    end
    chk("ts2_acks", acks, 1);

    // Reset while TS beat 2 is presented
    clear_logs(); set_ts(2'd0); os_req_i = 1;
    for (int i = 0; i < 20 && log_q.size() < 2; i++) tick();
    chk("rst_pre_beats", log_q.size(), 2);
    rst_ni = 0; model_reset();
    #1;
    chk("midrst_tvalid", m_axis_tvalid_o, 0);
    chk("midrst_tdata", m_axis_tdata_o, 0);
    chk("midrst_tuser", m_axis_tuser_o, 0);
    chk("midrst_tlast", m_axis_tlast_o, 0);
    chk("midrst_ack", os_ack_o, 0);
    tick(); tick();
    rst_ni = 1; clear_logs();
    run_until_ack(20, "rst_restart_timeout");
    tick();
    chk("restart_beats", log_q.size(), 4);
    if (log_q.size() > 0) chk("restart_b0", log_q[0].d, 32'h10F705BC);

    // Random traffic
    src_gaps = 1; skp_en_i = 1; data_en_i = 1;
    for (int i = 0; i < 3000; i++) begin
      m_axis_tready_i = ($urandom_range(3) != 0);
      if ($urandom_range(199) == 0) skp_en_i = !skp_en_i;
      if ($urandom_range(49) == 0) data_en_i = !data_en_i;
      if (last_ack) os_req_i = 0;
      else if (!os_req_i && $urandom_range(39) == 0) begin
        os_req_i = 1; os_type_i = 2'($urandom_range(3));
      end
      if (os_req_i) begin
        link_num_i = 8'($urandom); lane_num_i = 8'($urandom); n_fts_i = 8'($urandom);
        rate_id_i = 8'($urandom); train_ctrl_i = 8'($urandom);
        pad_link_i = 1'($urandom); pad_lane_i = 1'($urandom);
      end
      if (src_q.size() == 0 && $urandom_range(7) == 0) begin
        np = $urandom_range(1, 12);
        for (int j = 0; j < np; j++) begin
          b.d = $urandom; b.k = 4'($urandom); b.u = 4'($urandom); b.l = (j == np - 1);
          src_q.push_back(b);
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
